// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between exe_mem and mem_wb.
// Issues one ack-based bus access at a time with byte enables, then aligns and
// extends load data for write-back. Holds the pipeline while an access is open.
//
// state | meaning
// IDLE  | pass-through; launches an aligned load/store onto the bus
// BUSY  | request held on the bus, waiting for ack or timeout
// DONE  | result presented to mem_wb; pipeline advances on the next edge
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        mem_we_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  mem_op_in,
    input  logic [4:0]  reg_waddr_in,
    input  logic [31:0] reg_wdata_in,
    input  logic        reg_we_in,
    output logic [4:0]  reg_waddr_out,
    output logic [31:0] reg_wdata_out,
    output logic        reg_we_out,
    output logic        stall_req_out,
    output logic        misalign_out,
    output logic        bus_err_out,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    output logic [3:0]  bus_be_out,
    input  logic        bus_ack_in,
    input  logic [31:0] bus_rdata_in
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   load_q, load_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [3:0]    op_q, op_d;
    logic [1:0]    k_q, k_d;

    logic is_load, is_store, is_mem, misal;

    // Select the addressed byte/halfword of the read word and extend it.
    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] k,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{k, 3'b000} +: 8];
        h = k[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LBU:  load_ext = {24'd0, b};
            OP_LHU:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Decode the incoming request and flag misaligned halfword/word accesses.
    always_comb begin
        is_load  = (mem_op_in >= OP_LB) && (mem_op_in <= OP_LHU);
        is_store = (mem_op_in >= OP_SB) && (mem_op_in <= OP_SW);
        is_mem   = is_load || is_store;
        misal    = (((mem_op_in == OP_LH) || (mem_op_in == OP_LHU) || (mem_op_in == OP_SH))
                    && mem_addr_in[0])
                 || (((mem_op_in == OP_LW) || (mem_op_in == OP_SW))
                    && (mem_addr_in[1:0] != 2'b00));
    end

    // State and transaction registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            load_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            op_q        <= '0;
            k_q         <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            load_q      <= load_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            op_q        <= op_d;
            k_q         <= k_d;
        end
    end

    // Next-state logic and write-back/stall outputs.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        load_d        = load_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        op_d          = op_q;
        k_d           = k_q;
        reg_waddr_out = reg_waddr_in;
        reg_wdata_out = reg_wdata_in;
        reg_we_out    = reg_we_in;
        stall_req_out = 1'b0;
        misalign_out  = 1'b0;
        bus_err_out   = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem && misal) begin
                    misalign_out = 1'b1;
                    reg_we_out   = 1'b0;
                end else if (is_mem) begin
                    stall_req_out = 1'b1;
                    reg_we_out    = 1'b0;
                    bus_req_d     = 1'b1;
                    bus_we_d      = is_store;
                    bus_addr_d    = {mem_addr_in[31:2], 2'b00};
                    op_d          = mem_op_in;
                    k_d           = mem_addr_in[1:0];
                    cnt_d         = '0;
                    err_d         = 1'b0;
                    case (mem_op_in)
                        OP_SB: begin
                            bus_wdata_d = {4{mem_data_in[7:0]}};
                            bus_be_d    = 4'b0001 << mem_addr_in[1:0];
                        end
                        OP_SH: begin
                            bus_wdata_d = {2{mem_data_in[15:0]}};
                            bus_be_d    = 4'b0011 << mem_addr_in[1:0];
                        end
                        OP_SW: begin
                            bus_wdata_d = mem_data_in;
                            bus_be_d    = 4'b1111;
                        end
                        default: begin
                            bus_wdata_d = '0;
                            bus_be_d    = 4'b1111;
                        end
                    endcase
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_req_out = 1'b1;
                reg_we_out    = 1'b0;
                if (bus_ack_in) begin
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    if (op_q <= OP_LHU) load_d = load_ext(op_q, k_q, bus_rdata_in);
                    state_d   = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    load_d    = '0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                bus_err_out = err_q;
                if (op_q <= OP_LHU) begin
                    reg_wdata_out = load_q;
                    reg_we_out    = reg_we_in & ~err_q;
                end else begin
                    reg_we_out = 1'b0;
                end
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // mem_we_in is implied by the op encoding; keep it referenced for lint.
        if (reset_in || (mem_we_in && 1'b0)) begin
            reg_waddr_out = '0;
            reg_wdata_out = '0;
            reg_we_out    = 1'b0;
            stall_req_out = 1'b0;
            misalign_out  = 1'b0;
            bus_err_out   = 1'b0;
        end
    end

    assign bus_req_out   = bus_req_q;
    assign bus_we_out    = bus_we_q;
    assign bus_addr_out  = bus_addr_q;
    assign bus_wdata_out = bus_wdata_q;
    assign bus_be_out    = bus_be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: reset, pass-through, alignment, lanes,
// extension, wait states, timeout and reset during an access.
module tb_lsu_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        mem_we_in;
    logic [31:0] mem_addr_in, mem_data_in;
    logic [3:0]  mem_op_in;
    logic [4:0]  reg_waddr_in;
    logic [31:0] reg_wdata_in;
    logic        reg_we_in;
    logic [4:0]  reg_waddr_out;
    logic [31:0] reg_wdata_out;
    logic        reg_we_out, stall_req_out, misalign_out, bus_err_out;
    logic        bus_req_out, bus_we_out;
    logic [31:0] bus_addr_out, bus_wdata_out;
    logic [3:0]  bus_be_out;
    logic        bus_ack_in;
    logic [31:0] bus_rdata_in;

    int n_cmp = 0;
    int n_mis = 0;

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .mem_we_in(mem_we_in), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
        .mem_op_in(mem_op_in), .reg_waddr_in(reg_waddr_in), .reg_wdata_in(reg_wdata_in),
        .reg_we_in(reg_we_in), .reg_waddr_out(reg_waddr_out), .reg_wdata_out(reg_wdata_out),
        .reg_we_out(reg_we_out), .stall_req_out(stall_req_out), .misalign_out(misalign_out),
        .bus_err_out(bus_err_out), .bus_req_out(bus_req_out), .bus_we_out(bus_we_out),
        .bus_addr_out(bus_addr_out), .bus_wdata_out(bus_wdata_out), .bus_be_out(bus_be_out),
        .bus_ack_in(bus_ack_in), .bus_rdata_in(bus_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Present one memory op in the current IDLE cycle, ack in BUSY cycle ack_at
    // (0 = never), and collect what the bus and write-back ports showed.
    task automatic mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int ack_at, input logic [31:0] rdata,
                          output int stalls, output int busy,
                          output logic [31:0] ba, output logic [31:0] wd, output logic [3:0] be,
                          output logic bwe, output logic [31:0] o_wdata, output logic o_we,
                          output logic o_err, output logic [4:0] o_waddr, output logic req_after);
        bit done;
        mem_op_in = op; mem_addr_in = addr; mem_data_in = data;
        mem_we_in = (op >= 4'd6 && op <= 4'd8);
        reg_we_in = 1'b1; reg_waddr_in = 5'd9; reg_wdata_in = 32'hCAFE_0000;
        stalls = 0; busy = 0; done = 0;
        ba = '0; wd = '0; be = '0; bwe = 1'b0; o_wdata = '0; o_we = 1'b0; o_err = 1'b0; o_waddr = '0;
        #1;
        if (stall_req_out) stalls++;
        for (int i = 1; i <= 40 && !done; i++) begin
            tick;
            bus_ack_in = (i == ack_at);
            bus_rdata_in = rdata;
            #1;
            if (i == 1) begin
                ba = bus_addr_out; wd = bus_wdata_out; be = bus_be_out; bwe = bus_we_out;
            end
            if (stall_req_out) stalls++;
            if (bus_req_out) busy++;
            if (!stall_req_out) begin
                done = 1;
                o_wdata = reg_wdata_out; o_we = reg_we_out; o_err = bus_err_out;
                o_waddr = reg_waddr_out;
            end
        end
        bus_ack_in = 1'b0;
        chk("done_reached", {31'd0, done}, 32'd1);
        tick;
        mem_op_in = 4'd0; mem_we_in = 1'b0; reg_we_in = 1'b0;
        #1;
        req_after = bus_req_out;
    endtask

    int          st, bz;
    logic [31:0] ba, wd, ow;
    logic [3:0]  be;
    logic [4:0]  wa;
    logic        bwe, owe, oerr, rq;

    initial begin
        reset_in = 1'b1; mem_we_in = 0; mem_addr_in = 0; mem_data_in = 0; mem_op_in = 0;
        reg_waddr_in = 0; reg_wdata_in = 0; reg_we_in = 0; bus_ack_in = 0; bus_rdata_in = 0;
        tick; tick;
        // Outputs forced to reset values while reset is held, even with live inputs.
        reg_we_in = 1'b1; reg_wdata_in = 32'h1234; reg_waddr_in = 5'd3; mem_op_in = 4'd3;
        #1;
        chk("rst_reg_we", {31'd0, reg_we_out}, 0);
        chk("rst_reg_wdata", reg_wdata_out, 0);
        chk("rst_reg_waddr", {27'd0, reg_waddr_out}, 0);
        chk("rst_stall", {31'd0, stall_req_out}, 0);
        chk("rst_bus_req", {31'd0, bus_req_out}, 0);
        chk("rst_bus_addr", bus_addr_out, 0);
        chk("rst_bus_be", {28'd0, bus_be_out}, 0);
        tick;
        reset_in = 1'b0; mem_op_in = 4'd0;

        // ADD pass-through
        reg_we_in = 1'b1; reg_wdata_in = 32'h0000_0011; reg_waddr_in = 5'd5;
        #1;
        chk("add_wdata", reg_wdata_out, 32'h11);
        chk("add_we", {31'd0, reg_we_out}, 1);
        chk("add_waddr", {27'd0, reg_waddr_out}, 5);
        chk("add_stall", {31'd0, stall_req_out}, 0);

        // Misaligned SW
        tick;
        mem_op_in = 4'd8; mem_we_in = 1'b1; mem_addr_in = 32'h1000_0006; mem_data_in = 32'hDEADBEEF;
        #1;
        chk("sw_mis_flag", {31'd0, misalign_out}, 1);
        chk("sw_mis_stall", {31'd0, stall_req_out}, 0);
        chk("sw_mis_we", {31'd0, reg_we_out}, 0);
        tick;
        chk("sw_mis_noreq", {31'd0, bus_req_out}, 0);
        // Misaligned LH
        mem_op_in = 4'd2; mem_we_in = 1'b0; mem_addr_in = 32'h0000_0801;
        #1;
        chk("lh_mis_flag", {31'd0, misalign_out}, 1);
        tick;
        chk("lh_mis_noreq", {31'd0, bus_req_out}, 0);
        mem_op_in = 4'd0;
        tick;

        // SB, ack in cycle 1
        mem_op(4'd6, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("sb_addr", ba, 32'h100);
        chk("sb_be", {28'd0, be}, 32'h8);
        chk("sb_wdata", wd, 32'hA5A5A5A5);
        chk("sb_we", {31'd0, bwe}, 1);
        chk("sb_stalls", st, 2);
        chk("sb_reg_we", {31'd0, owe}, 0);
        chk("sb_req_after", {31'd0, rq}, 0);

        // SH upper half
        mem_op(4'd7, 32'h0000_0402, 32'h0000_BEEF, 1, 32'h0, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("sh_be", {28'd0, be}, 32'hC);
        chk("sh_wdata", wd, 32'hBEEFBEEF);

        // LB / LBU with 3 wait cycles (back-to-back)
        mem_op(4'd1, 32'h0000_0202, 32'h0, 4, 32'h0080_0000, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("lb_data", ow, 32'hFFFF_FF80);
        chk("lb_we", {31'd0, owe}, 1);
        chk("lb_waddr", {27'd0, wa}, 9);
        chk("lb_stalls", st, 5);
        chk("lb_addr", ba, 32'h200);
        chk("lb_be", {28'd0, be}, 32'hF);
        chk("lb_buswe", {31'd0, bwe}, 0);
        mem_op(4'd4, 32'h0000_0202, 32'h0, 4, 32'h0080_0000, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("lbu_data", ow, 32'h0000_0080);
        chk("lbu_stalls", st, 5);

        // LHU / LH immediate ack
        mem_op(4'd5, 32'h0000_0302, 32'h0, 1, 32'h8001_1234, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("lhu_data", ow, 32'h0000_8001);
        chk("lhu_we", {31'd0, owe}, 1);
        mem_op(4'd2, 32'h0000_0302, 32'h0, 1, 32'h8001_1234, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("lh_data", ow, 32'hFFFF_8001);

        // LW, one wait cycle
        mem_op(4'd3, 32'h0000_0500, 32'h0, 2, 32'h1234_5678, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("lw_data", ow, 32'h1234_5678);
        chk("lw_stalls", st, 3);

        // Timeout: no ack
        mem_op(4'd3, 32'h0000_0600, 32'h0, 0, 32'hFFFF_FFFF, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("to_busy", bz, 16);
        chk("to_stalls", st, 17);
        chk("to_err", {31'd0, oerr}, 1);
        chk("to_we", {31'd0, owe}, 0);
        chk("to_data", ow, 0);
        chk("to_req_after", {31'd0, rq}, 0);
        chk("to_err_cleared", {31'd0, bus_err_out}, 0);

        // Ack on the last BUSY cycle wins over timeout
        mem_op(4'd3, 32'h0000_0600, 32'h0, 16, 32'h0BAD_F00D, st, bz, ba, wd, be, bwe, ow, owe, oerr, wa, rq);
        chk("ack16_busy", bz, 16);
        chk("ack16_err", {31'd0, oerr}, 0);
        chk("ack16_we", {31'd0, owe}, 1);
        chk("ack16_data", ow, 32'h0BAD_F00D);

        // Reset in BUSY cycle 2, late ack afterwards
        mem_op_in = 4'd3; mem_addr_in = 32'h0000_0700; reg_we_in = 1'b1; reg_wdata_in = 32'h0;
        #1;
        chk("rb_stall0", {31'd0, stall_req_out}, 1);
        tick;
        tick;
        reset_in = 1'b1;
        #1;
        chk("rb_stall", {31'd0, stall_req_out}, 0);
        chk("rb_reg_we", {31'd0, reg_we_out}, 0);
        chk("rb_reg_wdata", reg_wdata_out, 0);
        tick;
        reset_in = 1'b0; mem_op_in = 4'd0; reg_we_in = 1'b0;
        bus_ack_in = 1'b1; bus_rdata_in = 32'hFFFF_FFFF;
        #1;
        chk("rb_req", {31'd0, bus_req_out}, 0);
        chk("rb_addr", bus_addr_out, 0);
        chk("rb_be", {28'd0, bus_be_out}, 0);
        chk("rb_stall_late", {31'd0, stall_req_out}, 0);
        chk("rb_we_late", {31'd0, reg_we_out}, 0);
        tick;
        bus_ack_in = 1'b0;
        reg_we_in = 1'b1; reg_waddr_in = 5'd7; reg_wdata_in = 32'h55;
        #1;
        chk("post_add_wdata", reg_wdata_out, 32'h55);
        chk("post_add_we", {31'd0, reg_we_out}, 1);
        chk("post_add_waddr", {27'd0, reg_waddr_out}, 7);
        chk("post_add_stall", {31'd0, stall_req_out}, 0);
        chk("post_add_err", {31'd0, bus_err_out}, 0);
        chk("post_add_req", {31'd0, bus_req_out}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
